map_loader: RTL and testbench

MAP_LOADER -- requirements
Module: map_loader

---
 rtl/map_loader.sv | 246 ++++++++++++++++++++++++
 tb/tb_map_loader.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_loader.sv
// map_loader: receives a framed map over a byte stream and writes it into a map memory.
//
// Frame: SYNC, row, col, orientation, ROWS*COLS cell bytes (row-major, col fastest), checksum.
// The checksum is the modulo-256 sum of every byte after SYNC, excluding the checksum itself.
//
// Ports
//   clk_i               single clock, rising edge
//   reset_i             asynchronous, active-high reset
//   in_valid_i          in_data_i holds a byte
//   in_data_i[7:0]      frame byte
//   in_ready_o          byte accepted this cycle when in_valid_i is also high
//   mem_we_o            one-cycle map cell write strobe
//   mem_addr_o[7:0]     map cell index, row*COLS+col
//   mem_wdata_o[3:0]    map cell value
//   robo_row_o[4:0]     robot start row of the last good frame
//   robo_col_o[5:0]     robot start column of the last good frame
//   robo_orientacao_o   robot start orientation of the last good frame
//   map_valid_o         last frame loaded without error
//   done_o              one-cycle pulse, frame completed
//   error_o             one-cycle pulse, frame aborted
module map_loader #(
    parameter int unsigned ROWS = 10,
    parameter int unsigned COLS = 20,
    parameter logic [7:0]  SYNC = 8'hA5
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       in_valid_i,
    input  logic [7:0] in_data_i,
    output logic       in_ready_o,
    output logic       mem_we_o,
    output logic [7:0] mem_addr_o,
    output logic [3:0] mem_wdata_o,
    output logic [4:0] robo_row_o,
    output logic [5:0] robo_col_o,
    output logic [1:0] robo_orientacao_o,
    output logic       map_valid_o,
    output logic       done_o,
    output logic       error_o
);

    localparam logic [7:0] RowMax  = 8'(ROWS - 1);
    localparam logic [7:0] ColMax  = 8'(COLS - 1);
    localparam logic [7:0] OriMax  = 8'd3;
    localparam logic [7:0] CellMax = 8'h0F;

    typedef enum logic [2:0] {
        StIdle,
        StHrow,
        StHcol,
        StHori,
        StCells,
        StChk,
        StFin
    } state_e;

    state_e     state_q, state_d;

    // Header shadows; copied to the robot outputs only once the checksum matches.
    logic [4:0] row_sh_q, row_sh_d;
    logic [5:0] col_sh_q, col_sh_d;
    logic [1:0] ori_sh_q, ori_sh_d;

    // Cell index tracking: addr_q is the linear index, row/col counters detect the last cell.
    logic [7:0] addr_q, addr_d;
    logic [7:0] col_cnt_q, col_cnt_d;
    logic [7:0] row_cnt_q, row_cnt_d;
    logic [7:0] sum_q, sum_d;

    logic       mem_we_q, mem_we_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [3:0] mem_wdata_q, mem_wdata_d;
    logic [4:0] robo_row_q, robo_row_d;
    logic [5:0] robo_col_q, robo_col_d;
    logic [1:0] robo_ori_q, robo_ori_d;
    logic       map_valid_q, map_valid_d;
    logic       error_q, error_d;

    logic       xfer;
    logic       last_cell;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            row_sh_q    <= '0;
            col_sh_q    <= '0;
            ori_sh_q    <= '0;
            addr_q      <= '0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            sum_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            robo_row_q  <= '0;
            robo_col_q  <= '0;
            robo_ori_q  <= '0;
            map_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_sh_q    <= row_sh_d;
            col_sh_q    <= col_sh_d;
            ori_sh_q    <= ori_sh_d;
            addr_q      <= addr_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            sum_q       <= sum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            robo_row_q  <= robo_row_d;
            robo_col_q  <= robo_col_d;
            robo_ori_q  <= robo_ori_d;
            map_valid_q <= map_valid_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_sh_d    = row_sh_q;
        col_sh_d    = col_sh_q;
        ori_sh_d    = ori_sh_q;
        addr_d      = addr_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        robo_row_d  = robo_row_q;
        robo_col_d  = robo_col_q;
        robo_ori_d  = robo_ori_q;
        map_valid_d = map_valid_q;
        error_d     = 1'b0;

        in_ready_o  = (state_q != StFin);
        done_o      = (state_q == StFin);
        xfer        = in_valid_i && in_ready_o;
        last_cell   = (row_cnt_q == RowMax) && (col_cnt_q == ColMax);

        unique case (state_q)
            StIdle: begin
                if (xfer && (in_data_i == SYNC)) begin
                    state_d     = StHrow;
                    map_valid_d = 1'b0;
                    sum_d       = '0;
                end
            end
            StHrow: begin
                if (xfer) begin
                    if (in_data_i > RowMax) begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        row_sh_d = in_data_i[4:0];
                        sum_d    = sum_q + in_data_i;
                        state_d  = StHcol;
                    end
                end
            end
            StHcol: begin
                if (xfer) begin
                    if (in_data_i > ColMax) begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        col_sh_d = in_data_i[5:0];
                        sum_d    = sum_q + in_data_i;
                        state_d  = StHori;
                    end
                end
            end
            StHori: begin
                if (xfer) begin
                    if (in_data_i > OriMax) begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ori_sh_d  = in_data_i[1:0];
                        sum_d     = sum_q + in_data_i;
                        addr_d    = '0;
                        col_cnt_d = '0;
                        row_cnt_d = '0;
                        state_d   = StCells;
                    end
                end
            end
            StCells: begin
                if (xfer) begin
                    if (in_data_i > CellMax) begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = in_data_i[3:0];
                        sum_d       = sum_q + in_data_i;
                        addr_d      = addr_q + 8'd1;
                        if (col_cnt_q == ColMax) begin
                            col_cnt_d = '0;
                            row_cnt_d = row_cnt_q + 8'd1;
                        end else begin
                            col_cnt_d = col_cnt_q + 8'd1;
                        end
                        if (last_cell) begin
                            state_d = StChk;
                        end
                    end
                end
            end
            StChk: begin
                if (xfer) begin
                    if (in_data_i == sum_q) begin
                        // Robot outputs and map_valid are already updated during the FIN cycle.
                        robo_row_d  = row_sh_q;
                        robo_col_d  = col_sh_q;
                        robo_ori_d  = ori_sh_q;
                        map_valid_d = 1'b1;
                        state_d     = StFin;
                    end else begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_we_o          = mem_we_q;
    assign mem_addr_o        = mem_addr_q;
    assign mem_wdata_o       = mem_wdata_q;
    assign robo_row_o        = robo_row_q;
    assign robo_col_o        = robo_col_q;
    assign robo_orientacao_o = robo_ori_q;
    assign map_valid_o       = map_valid_q;
    assign error_o           = error_q;

endmodule

// File: tb/tb_map_loader.sv
// Self-checking bench for map_loader: frames are driven byte by byte, expected cell writes are
// queued as the cells are sent and popped when the DUT strobes mem_we.
module tb_map_loader;

    localparam int unsigned NROWS  = 10;
    localparam int unsigned NCOLS  = 20;
    localparam int unsigned NCELLS = NROWS * NCOLS;
    localparam logic [7:0]  SYNC_V = 8'hA5;

    typedef struct packed {
        logic [7:0] addr;
        logic [3:0] data;
    } wr_t;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [3:0] mem_wdata;
    logic [4:0] robo_row;
    logic [5:0] robo_col;
    logic [1:0] robo_ori;
    logic       map_valid;
    logic       done;
    logic       error;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    wr_t exp_q[$];
    wr_t mon_e;

    logic [4:0] exp_row = '0;
    logic [5:0] exp_col = '0;
    logic [1:0] exp_ori = '0;

    map_loader #(
        .ROWS(NROWS),
        .COLS(NCOLS),
        .SYNC(SYNC_V)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .in_valid_i        (in_valid),
        .in_data_i         (in_data),
        .in_ready_o        (in_ready),
        .mem_we_o          (mem_we),
        .mem_addr_o        (mem_addr),
        .mem_wdata_o       (mem_wdata),
        .robo_row_o        (robo_row),
        .robo_col_o        (robo_col),
        .robo_orientacao_o (robo_ori),
        .map_valid_o       (map_valid),
        .done_o            (done),
        .error_o           (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write scoreboard and pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                wr_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_unexpected: got addr %0d data %0h, required no write",
                             mem_addr, mem_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
                        n_fail++;
                        $display("FAIL write_order: got addr %0d data %0h, required addr %0d data %0h",
                                 mem_addr, mem_wdata, mon_e.addr, mon_e.data);
                    end
                end
            end
            if (done) done_cnt++;
            if (error) err_cnt++;
            if (done && error) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_error_overlap: got done=1 error=1, required not both");
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns #1 after the edge on which the byte was transferred.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 8) begin
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required 1", n);
        end
    endtask

    // Sends a frame; bad_cell >= 0 replaces that cell with 8'h10 and stops the frame there.
    task automatic send_frame(input logic [7:0] r, input logic [7:0] c, input logic [7:0] o,
                              input int bad_cell, input logic [7:0] sum_adj, input bit gaps);
        logic [7:0] sum;
        logic [7:0] v;
        sum = r + c + o;
        send_byte(SYNC_V, gaps);
        send_byte(r, gaps);
        send_byte(c, gaps);
        send_byte(o, gaps);
        for (int i = 0; i < int'(NCELLS); i++) begin
            if (i == bad_cell) begin
                send_byte(8'h10, gaps);
                return;
            end
            v = 8'(i % 16);
            exp_q.push_back('{addr: 8'(i), data: v[3:0]});
            send_byte(v, gaps);
            sum = sum + v;
        end
        send_byte(sum + sum_adj, gaps);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        idle(2);
        n_checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 8'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_mem: got ready=%b we=%b addr=%0d data=%0h, required 1 0 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata);
        end
        n_checks++;
        if ({robo_row, robo_col, robo_ori, map_valid, done, error} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got row=%0d col=%0d ori=%0d mv=%b done=%b err=%b, required all 0",
                     robo_row, robo_col, robo_ori, map_valid, done, error);
        end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_good_frame();
        int w0 = wr_cnt;
        int d0 = done_cnt;
        int e0 = err_cnt;
        send_frame(8'd9, 8'd0, 8'd1, -1, 8'd0, 1'b0);
        n_checks++;
        if (done !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL good_fin_cycle: got done=%b ready=%b, required done=1 ready=0", done, in_ready);
        end
        exp_row = 5'd9; exp_col = 6'd0; exp_ori = 2'd1;
        idle(3);
        n_checks++;
        if (wr_cnt - w0 != 200 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL good_writes: got %0d writes (%0d pending), required 200", wr_cnt - w0, exp_q.size());
        end
        n_checks++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            n_fail++;
            $display("FAIL good_pulses: got done %0d error %0d, required 1 0", done_cnt - d0, err_cnt - e0);
        end
        n_checks++;
        if ({robo_row, robo_col, robo_ori, map_valid} !== {exp_row, exp_col, exp_ori, 1'b1}) begin
            n_fail++;
            $display("FAIL good_robot: got row=%0d col=%0d ori=%0d mv=%b, required %0d %0d %0d 1",
                     robo_row, robo_col, robo_ori, map_valid, exp_row, exp_col, exp_ori);
        end
    endtask

    task automatic test_bad_checksum();
        int w0 = wr_cnt;
        int d0 = done_cnt;
        int e0 = err_cnt;
        send_frame(8'd3, 8'd7, 8'd2, -1, 8'd1, 1'b0);
        n_checks++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL chk_error_timing: got error=%b after checksum, required 1", error);
        end
        idle(3);
        n_checks++;
        if (wr_cnt - w0 != 200 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL chk_writes: got %0d writes, required 200", wr_cnt - w0);
        end
        n_checks++;
        if (done_cnt - d0 != 0 || err_cnt - e0 != 1) begin
            n_fail++;
            $display("FAIL chk_pulses: got done %0d error %0d, required 0 1", done_cnt - d0, err_cnt - e0);
        end
        n_checks++;
        if ({robo_row, robo_col, robo_ori, map_valid} !== {exp_row, exp_col, exp_ori, 1'b0}) begin
            n_fail++;
            $display("FAIL chk_robot: got row=%0d col=%0d ori=%0d mv=%b, required %0d %0d %0d 0",
                     robo_row, robo_col, robo_ori, map_valid, exp_row, exp_col, exp_ori);
        end
    endtask

    task automatic test_header_abort();
        int w0 = wr_cnt;
        int d0 = done_cnt;
        int e0 = err_cnt;
        send_byte(SYNC_V, 1'b0);
        send_byte(8'd9, 1'b0);
        send_byte(8'd20, 1'b0);
        n_checks++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL hdr_error_timing: got error=%b after col=20, required 1", error);
        end
        idle(2);
        n_checks++;
        if (wr_cnt - w0 != 0 || err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            n_fail++;
            $display("FAIL hdr_abort: got writes %0d error %0d done %0d, required 0 1 0",
                     wr_cnt - w0, err_cnt - e0, done_cnt - d0);
        end
        w0 = wr_cnt;
        d0 = done_cnt;
        send_frame(8'd5, 8'd19, 8'd3, -1, 8'd0, 1'b0);
        exp_row = 5'd5; exp_col = 6'd19; exp_ori = 2'd3;
        idle(3);
        n_checks++;
        if (wr_cnt - w0 != 200 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL hdr_recover: got writes %0d done %0d, required 200 1", wr_cnt - w0, done_cnt - d0);
        end
        n_checks++;
        if ({robo_row, robo_col, robo_ori, map_valid} !== {exp_row, exp_col, exp_ori, 1'b1}) begin
            n_fail++;
            $display("FAIL hdr_recover_robot: got row=%0d col=%0d ori=%0d mv=%b, required %0d %0d %0d 1",
                     robo_row, robo_col, robo_ori, map_valid, exp_row, exp_col, exp_ori);
        end
    endtask

    task automatic test_bad_cell();
        int w0 = wr_cnt;
        int d0 = done_cnt;
        int e0 = err_cnt;
        send_frame(8'd1, 8'd2, 8'd0, 45, 8'd0, 1'b0);
        idle(3);
        n_checks++;
        if (wr_cnt - w0 != 45 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL cell_writes: got %0d writes, required 45", wr_cnt - w0);
        end
        n_checks++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            n_fail++;
            $display("FAIL cell_pulses: got error %0d done %0d, required 1 0", err_cnt - e0, done_cnt - d0);
        end
        n_checks++;
        if ({robo_row, robo_col, robo_ori, map_valid} !== {exp_row, exp_col, exp_ori, 1'b0}) begin
            n_fail++;
            $display("FAIL cell_robot: got row=%0d col=%0d ori=%0d mv=%b, required %0d %0d %0d 0",
                     robo_row, robo_col, robo_ori, map_valid, exp_row, exp_col, exp_ori);
        end
        // Back in idle: plain cell-valued bytes without SYNC must not write anything.
        w0 = wr_cnt;
        send_byte(8'd3, 1'b0);
        send_byte(8'd4, 1'b0);
        idle(2);
        n_checks++;
        if (wr_cnt - w0 != 0) begin
            n_fail++;
            $display("FAIL cell_idle: got %0d writes after abort, required 0", wr_cnt - w0);
        end
    endtask

    task automatic test_gaps_junk();
        int w0 = wr_cnt;
        int d0 = done_cnt;
        int e0 = err_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_frame(8'd9, 8'd0, 8'd1, -1, 8'd0, 1'b1);
        exp_row = 5'd9; exp_col = 6'd0; exp_ori = 2'd1;
        idle(3);
        n_checks++;
        if (wr_cnt - w0 != 200 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL gaps_writes: got %0d writes, required 200", wr_cnt - w0);
        end
        n_checks++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            n_fail++;
            $display("FAIL gaps_pulses: got done %0d error %0d, required 1 0", done_cnt - d0, err_cnt - e0);
        end
        n_checks++;
        if ({robo_row, robo_col, robo_ori, map_valid} !== {exp_row, exp_col, exp_ori, 1'b1}) begin
            n_fail++;
            $display("FAIL gaps_robot: got row=%0d col=%0d ori=%0d mv=%b, required %0d %0d %0d 1",
                     robo_row, robo_col, robo_ori, map_valid, exp_row, exp_col, exp_ori);
        end
    endtask

    task automatic test_reset_mid_frame();
        int w0 = wr_cnt;
        int d0 = done_cnt;
        int e0 = err_cnt;
        send_byte(SYNC_V, 1'b0);
        send_byte(8'd2, 1'b0);
        send_byte(8'd4, 1'b0);
        send_byte(8'd1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back('{addr: 8'(i), data: 4'(i % 16)});
            send_byte(8'(i % 16), 1'b0);
        end
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'd4;
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 8'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_mem: got ready=%b we=%b addr=%0d data=%0h, required 1 0 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata);
        end
        n_checks++;
        if ({robo_row, robo_col, robo_ori, map_valid, done, error} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got row=%0d col=%0d ori=%0d mv=%b done=%b err=%b, required all 0",
                     robo_row, robo_col, robo_ori, map_valid, done, error);
        end
        exp_row = '0; exp_col = '0; exp_ori = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        // Former cell bytes without a new SYNC must be ignored.
        send_byte(8'd5, 1'b0);
        send_byte(8'd6, 1'b0);
        idle(3);
        n_checks++;
        if (wr_cnt - w0 != 100 || exp_q.size() != 0 || done_cnt != d0 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL rst_mid_abort: got writes %0d done %0d error %0d, required 100 0 0",
                     wr_cnt - w0, done_cnt - d0, err_cnt - e0);
        end
        w0 = wr_cnt;
        send_frame(8'd7, 8'd11, 8'd0, -1, 8'd0, 1'b0);
        exp_row = 5'd7; exp_col = 6'd11; exp_ori = 2'd0;
        idle(3);
        n_checks++;
        if (wr_cnt - w0 != 200 || done_cnt - d0 != 1 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL rst_recover: got writes %0d done %0d, required 200 1", wr_cnt - w0, done_cnt - d0);
        end
        n_checks++;
        if ({robo_row, robo_col, robo_ori, map_valid} !== {exp_row, exp_col, exp_ori, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_recover_robot: got row=%0d col=%0d ori=%0d mv=%b, required %0d %0d %0d 1",
                     robo_row, robo_col, robo_ori, map_valid, exp_row, exp_col, exp_ori);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_header_abort();
        test_bad_cell();
        test_gaps_junk();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
